serial_addsub_wide: RTL and testbench

SERIAL_ADDSUB_WIDE -- requirements
Module: serial_addsub_wide

---
 rtl/serial_addsub_wide.sv | 128 ++++++++++++
 tb/tb_serial_addsub_wide.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_wide.sv
// Digit-serial adder/subtractor for words of arbitrary length.
// Operands arrive least-significant digit first, W bits per valid cycle.
// The mode is taken from the first digit of each word and the carry is
// chained between digits. The result digit, the final carry and the signed
// overflow flag are registered with one cycle of latency.
module serial_addsub_wide #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vld,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         last,
    output logic         out_vld,
    output logic [W-1:0] out_sum,
    output logic         out_last,
    output logic         out_carry,
    output logic         out_ovf
);

    // Word-tracking state
    logic         c_reg,         c_next;
    logic         in_word_reg,   in_word_next;
    logic         m_reg,         m_next;

    // Registered result
    logic         out_vld_reg,   out_vld_next;
    logic [W-1:0] out_sum_reg,   out_sum_next;
    logic         out_last_reg,  out_last_next;
    logic         out_carry_reg, out_carry_next;
    logic         out_ovf_reg,   out_ovf_next;

    // Digit datapath
    logic         first_digit;
    logic         mode;
    logic         cin;
    logic [W-1:0] b_eff;
    logic [W:0]   total;
    logic [W-1:0] digit_sum;
    logic         digit_co;
    logic         msb_cin;
    logic         digit_ovf;

    // The first digit of a word uses the live sub input for both the
    // operand inversion and the carry-in (the +1 of two's complement);
    // later digits use the latched mode and the chained carry.
    assign first_digit = ~in_word_reg;
    assign mode        = first_digit ? sub : m_reg;
    assign cin         = first_digit ? sub : c_reg;

    // Conditionally invert B one bit at a time for subtraction.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_b_eff
            assign b_eff[gi] = b[gi] ^ mode;
        end
    endgenerate

    assign total     = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
    assign digit_sum = total[W-1:0];
    assign digit_co  = total[W];

    // Carry into the top bit is recovered from the sum bit; with W=1 this
    // collapses to the carry-in itself.
    assign msb_cin   = a[W-1] ^ b_eff[W-1] ^ digit_sum[W-1];
    assign digit_ovf = msb_cin ^ digit_co;

    // Next-state and next-output logic; idle cycles hold everything except
    // the valid/last strobes.
    always_comb begin
        c_next         = c_reg;
        in_word_next   = in_word_reg;
        m_next         = m_reg;
        out_vld_next   = vld;
        out_last_next  = vld & last;
        out_sum_next   = out_sum_reg;
        out_carry_next = out_carry_reg;
        out_ovf_next   = out_ovf_reg;

        if (vld) begin
            if (first_digit) begin
                m_next = sub;
            end
            if (last) begin
                c_next       = 1'b0;
                in_word_next = 1'b0;
            end else begin
                c_next       = digit_co;
                in_word_next = 1'b1;
            end
            out_sum_next   = digit_sum;
            out_carry_next = digit_co;
            out_ovf_next   = digit_ovf;
        end
    end

    // State and output registers; reset wins over an incoming digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_reg         <= 1'b0;
            in_word_reg   <= 1'b0;
            m_reg         <= 1'b0;
            out_vld_reg   <= 1'b0;
            out_sum_reg   <= '0;
            out_last_reg  <= 1'b0;
            out_carry_reg <= 1'b0;
            out_ovf_reg   <= 1'b0;
        end else begin
            c_reg         <= c_next;
            in_word_reg   <= in_word_next;
            m_reg         <= m_next;
            out_vld_reg   <= out_vld_next;
            out_sum_reg   <= out_sum_next;
            out_last_reg  <= out_last_next;
            out_carry_reg <= out_carry_next;
            out_ovf_reg   <= out_ovf_next;
        end
    end

    assign out_vld   = out_vld_reg;
    assign out_sum   = out_sum_reg;
    assign out_last  = out_last_reg;
    assign out_carry = out_carry_reg;
    assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_serial_addsub_wide.sv
// Bench for serial_addsub_wide: directed W=4 words plus a W=1 random run.
// A word-level integer model predicts every output cycle; predictions are
// queued when a digit is driven and popped when the registered result is due.
module tb_serial_addsub_wide;

    typedef struct packed {
        logic       vld;
        logic       last;
        logic [3:0] sum;
        logic       carry;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    // W=4 instance
    logic       v4, s4, l4;
    logic [3:0] a4, b4;
    logic       o4_vld, o4_last, o4_carry, o4_ovf;
    logic [3:0] o4_sum;

    // W=1 instance
    logic       v1, s1, l1;
    logic [0:0] a1, b1;
    logic       o1_vld, o1_last, o1_carry, o1_ovf;
    logic [0:0] o1_sum;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = W4, index 1 = W1
    int   m_c[2], m_in[2], m_m[2];
    exp_t held[2];
    exp_t sb_q[$];

    always #5 clk = ~clk;

    serial_addsub_wide #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .vld(v4), .a(a4), .b(b4), .sub(s4), .last(l4),
        .out_vld(o4_vld), .out_sum(o4_sum), .out_last(o4_last),
        .out_carry(o4_carry), .out_ovf(o4_ovf)
    );

    serial_addsub_wide #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .vld(v1), .a(a1), .b(b1), .sub(s1), .last(l1),
        .out_vld(o1_vld), .out_sum(o1_sum), .out_last(o1_last),
        .out_carry(o1_carry), .out_ovf(o1_ovf)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Arithmetic model: unsigned sum gives digit and carry, signed sum
    // range gives overflow.
    task automatic model(input int idx, input int w, input logic rv, input logic vv,
                         input int av, input int bv, input logic sv, input logic lv,
                         output exp_t e);
        int mask, half, first, mode, cin, beff, tot, sa, sbv, ssum;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        e = held[idx];
        e.vld = 1'b0;
        e.last = 1'b0;
        if (!rv) begin
            m_c[idx] = 0; m_in[idx] = 0; m_m[idx] = 0;
            e = '0;
        end else if (vv) begin
            first = (m_in[idx] == 0);
            mode  = first ? int'(sv) : m_m[idx];
            cin   = first ? int'(sv) : m_c[idx];
            beff  = mode ? (mask - bv) : bv;
            tot   = av + beff + cin;
            sa    = (av   >= half) ? av   - (1 << w) : av;
            sbv   = (beff >= half) ? beff - (1 << w) : beff;
            ssum  = sa + sbv + cin;
            e.vld   = 1'b1;
            e.last  = lv;
            e.sum   = 4'(tot & mask);
            e.carry = (tot >> w) != 0;
            e.ovf   = (ssum > half - 1) || (ssum < -half);
            if (first) m_m[idx] = sv;
            if (lv) begin m_c[idx] = 0; m_in[idx] = 0; end
            else begin m_c[idx] = (tot >> w); m_in[idx] = 1; end
        end
        held[idx] = e;
    endtask

    // One clock: drive at negedge, predict, then compare 1 time unit after posedge.
    task automatic step(input int idx, input logic rv, input logic vv, input logic [3:0] av,
                        input logic [3:0] bv, input logic sv, input logic lv);
        exp_t e, eo, got;
        @(negedge clk);
        rst_n = rv;
        v4 = 1'b0; v1 = 1'b0;
        if (idx == 0) begin
            v4 = vv; a4 = av; b4 = bv; s4 = sv; l4 = lv;
            model(0, 4, rv, vv, av, bv, sv, lv, e);
            model(1, 1, rv, 1'b0, 0, 0, 1'b0, 1'b0, eo);
        end else begin
            v1 = vv; a1 = av[0]; b1 = bv[0]; s1 = sv; l1 = lv;
            model(1, 1, rv, vv, int'(av[0]), int'(bv[0]), sv, lv, e);
            model(0, 4, rv, 1'b0, 0, 0, 1'b0, 1'b0, eo);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (idx == 0) got = '{o4_vld, o4_last, o4_sum, o4_carry, o4_ovf};
        else          got = '{o1_vld, o1_last, {3'b000, o1_sum}, o1_carry, o1_ovf};
        chk("out_vld",   {3'b0, got.vld},   {3'b0, e.vld});
        chk("out_last",  {3'b0, got.last},  {3'b0, e.last});
        chk("out_sum",   got.sum,           e.sum);
        chk("out_carry", {3'b0, got.carry}, {3'b0, e.carry});
        chk("out_ovf",   {3'b0, got.ovf},   {3'b0, e.ovf});
        $display("step idx=%0d rst_n=%0b vld=%0b a=%0h b=%0h sub=%0b last=%0b -> vld=%0b sum=%0h last=%0b c=%0b v=%0b",
                 idx, rv, vv, av, bv, sv, lv, got.vld, got.sum, got.last, got.carry, got.ovf);
    endtask

    // Fixed expectations for the documented example words.
    task automatic expect4(input string tag, input logic [3:0] sum, input logic lst,
                           input logic cy, input logic ov);
        chk({tag, "_sum"},   o4_sum,          sum);
        chk({tag, "_last"},  {3'b0, o4_last}, {3'b0, lst});
        chk({tag, "_carry"}, {3'b0, o4_carry}, {3'b0, cy});
        chk({tag, "_ovf"},   {3'b0, o4_ovf},  {3'b0, ov});
    endtask

    initial begin
        rst_n = 1'b0;
        v4 = 0; a4 = 0; b4 = 0; s4 = 0; l4 = 0;
        v1 = 0; a1 = 0; b1 = 0; s1 = 0; l1 = 0;
        for (int i = 0; i < 2; i++) begin
            m_c[i] = 0; m_in[i] = 0; m_m[i] = 0; held[i] = '0;
        end

        // Reset state, with a digit offered during reset that must be dropped
        step(0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
        expect4("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_vld", {3'b0, o4_vld}, 4'h0);

        // 0x37 + 0x19
        step(0, 1'b1, 1'b1, 4'h7, 4'h9, 1'b0, 1'b0);
        chk("add_d0_sum", o4_sum, 4'h0);
        step(0, 1'b1, 1'b1, 4'h3, 4'h1, 1'b0, 1'b1);
        expect4("add", 4'h5, 1'b1, 1'b0, 1'b0);

        // 0x50 - 0x19
        step(0, 1'b1, 1'b1, 4'h0, 4'h9, 1'b1, 1'b0);
        chk("sub_d0_sum", o4_sum, 4'h7);
        step(0, 1'b1, 1'b1, 4'h5, 4'h1, 1'b0, 1'b1);
        expect4("sub", 4'h3, 1'b1, 1'b1, 1'b0);

        // Single-digit 0x7 + 0x1: signed overflow
        step(0, 1'b1, 1'b1, 4'h7, 4'h1, 1'b0, 1'b1);
        expect4("single", 4'h8, 1'b1, 1'b0, 1'b1);
        step(0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        chk("single_vld_drop", {3'b0, o4_vld}, 4'h0);

        // 0x37 + 0x19 with three idle cycles between digits
        step(0, 1'b1, 1'b1, 4'h7, 4'h9, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b1, 1'b0, 4'hA, 4'hB, 1'b1, 1'b1);
            chk("gap_sum_held", o4_sum, 4'h0);
        end
        step(0, 1'b1, 1'b1, 4'h3, 4'h1, 1'b0, 1'b1);
        expect4("gap", 4'h5, 1'b1, 1'b0, 1'b0);

        // Reset mid-word discards the stale carry
        step(0, 1'b1, 1'b1, 4'h7, 4'h9, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b1, 4'h1, 4'h1, 1'b0, 1'b1);
        expect4("rst_mid", 4'h2, 1'b1, 1'b0, 1'b0);

        // sub on a later digit is ignored
        step(0, 1'b1, 1'b1, 4'h7, 4'h9, 1'b0, 1'b0);
        step(0, 1'b1, 1'b1, 4'h3, 4'h1, 1'b1, 1'b1);
        expect4("sub_ignored", 4'h5, 1'b1, 1'b0, 1'b0);

        // W=1 random regression
        for (int i = 0; i < 128; i++) begin
            step(1, 1'b1, ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 1)),
                 4'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 3));
        end
        step(1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
